// File: rtl/wave_mixer.sv
// wave_mixer: pulls one sample from each enabled oscillator voice per frame
// request, shifts each right by its own attenuation, sums them in a widened
// accumulator and saturates the result to the output sample width. The mixed
// sample is held on data_o until the next frame completes.
//
// Handshake: voice k transfers a sample in any cycle where valid_i[k] and
// ready_o[k] are both high. ready_o[k] is high only in GATHER, only for voices
// enabled at frame start that have not yet delivered this frame. valid_i
// without ready_o is ignored, and data_i need only be correct in the
// transfer cycle.
module wave_mixer #(
  parameter int width_p    = 16,
  parameter int channels_p = 4,
  parameter int atten_w_p  = 3,
  parameter int timeout_p  = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [channels_p-1:0]           en_i,
  input  logic [channels_p*atten_w_p-1:0] atten_i,
  input  logic [channels_p*width_p-1:0]   data_i,
  input  logic [channels_p-1:0]           valid_i,
  output logic [channels_p-1:0]           ready_o,
  input  logic                            frame_req_i,
  output logic [width_p-1:0]              data_o,
  output logic                            valid_o,
  output logic                            busy_o,
  output logic [15:0]                     clip_cnt_o,
  output logic                            overrun_o,
  output logic [1:0]                      state_o
);

  localparam int acc_w_lp = width_p + $clog2(channels_p);
  localparam int idx_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int tmo_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  localparam logic signed [acc_w_lp-1:0] sat_max_lp = acc_w_lp'((2 ** (width_p - 1)) - 1);
  localparam logic signed [acc_w_lp-1:0] sat_min_lp = -sat_max_lp - acc_w_lp'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    ACCUM  = 2'd2,
    SAT    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [channels_p-1:0]           shadow_en_q;
  logic [channels_p*atten_w_p-1:0] shadow_atten_q;
  logic [channels_p-1:0]           captured_q;
  logic [channels_p*width_p-1:0]   sample_q;
  logic [tmo_w_lp-1:0]             tmo_q;
  logic [idx_w_lp-1:0]             idx_q;
  logic signed [acc_w_lp-1:0]      acc_q;

  logic                            start;
  logic                            all_captured;
  logic                            tmo_done;
  logic                            last_voice;
  logic [channels_p-1:0]           handshake;
  logic signed [width_p-1:0]       cur_sample;
  logic [atten_w_p-1:0]            cur_atten;
  logic signed [acc_w_lp-1:0]      term;
  logic [width_p-1:0]              sat_val;
  logic                            clipped;

  assign start        = (state_q == IDLE) && frame_req_i;
  assign all_captured = &(captured_q | ~shadow_en_q);
  assign tmo_done     = (tmo_q == tmo_w_lp'(timeout_p - 1));
  assign last_voice   = (idx_q == idx_w_lp'(channels_p - 1));
  assign ready_o      = (state_q == GATHER) ? (shadow_en_q & ~captured_q) : '0;
  assign handshake    = valid_i & ready_o;
  assign busy_o       = (state_q != IDLE);
  assign state_o      = state_q;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_req_i) state_d = GATHER;
      GATHER:  if (all_captured || tmo_done) state_d = ACCUM;
      ACCUM:   if (last_voice) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current voice's contribution: sign-extended, arithmetically shifted,
  // zero when the voice never delivered this frame.
  always_comb begin
    cur_sample = sample_q[int'(idx_q)*width_p +: width_p];
    cur_atten  = shadow_atten_q[int'(idx_q)*atten_w_p +: atten_w_p];
    term       = '0;
    if (captured_q[idx_q]) begin
      term = $signed({{(acc_w_lp-width_p){cur_sample[width_p-1]}}, cur_sample}) >>> cur_atten;
    end
  end

  // Clamp the accumulator into the output sample range.
  always_comb begin
    sat_val = acc_q[width_p-1:0];
    clipped = 1'b0;
    if (acc_q > sat_max_lp) begin
      sat_val = sat_max_lp[width_p-1:0];
      clipped = 1'b1;
    end else if (acc_q < sat_min_lp) begin
      sat_val = sat_min_lp[width_p-1:0];
      clipped = 1'b1;
    end
  end

  // Frame datapath: shadow settings, sample capture, timeout and accumulation.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_en_q    <= '0;
      shadow_atten_q <= '0;
      captured_q     <= '0;
      sample_q       <= '0;
      tmo_q          <= '0;
      idx_q          <= '0;
      acc_q          <= '0;
    end else if (start) begin
      shadow_en_q    <= en_i;
      shadow_atten_q <= atten_i;
      captured_q     <= '0;
      tmo_q          <= '0;
      idx_q          <= '0;
      acc_q          <= '0;
    end else if (state_q == GATHER) begin
      tmo_q <= tmo_q + tmo_w_lp'(1);
      for (int k = 0; k < channels_p; k++) begin
        if (handshake[k]) begin
          captured_q[k]                   <= 1'b1;
          sample_q[k*width_p +: width_p] <= data_i[k*width_p +: width_p];
        end
      end
    end else if (state_q == ACCUM) begin
      acc_q <= acc_q + term;
      idx_q <= last_voice ? '0 : idx_q + idx_w_lp'(1);
    end
  end

  // Output registers: mixed sample, first-result flag, clip counter, overrun.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      clip_cnt_o <= '0;
      overrun_o  <= 1'b0;
    end else begin
      if (state_q == SAT) begin
        data_o  <= sat_val;
        valid_o <= 1'b1;
        if (clipped && (clip_cnt_o != 16'hFFFF)) clip_cnt_o <= clip_cnt_o + 16'd1;
      end
      if (frame_req_i && busy_o) overrun_o <= 1'b1;
    end
  end

endmodule
